mic_decimator: RTL and testbench
================================

Name: mic_decimator

Overview:
- Sits directly downstream of the I2S microphone receiver (microphones).
- Consumes its 24-bit signed PCM sample stream and averages each block of 2^DECIM_LOG2 consecutive samples (boxcar decimation).
- Presents each decimated sample on a valid/ready output to the downstream audio-processing stage.
- Upstream has no backpressure; when the output buffer cannot accept a new result, that result is dropped and the event is flagged.

Parameters:
SAMPLE_WIDTH, 24, width of signed input and output samples
DECIM_LOG2, 3, log2 of decimation factor N (N = 8 by default); legal range 1..8

Ports:
clk_in  input  1  system clock (100 MHz); all logic in this single domain
rst_in  input  1  asynchronous, active-low reset
sample_in  input  SAMPLE_WIDTH  signed two's-complement sample from the receiver
sample_valid_in  input  1  single-cycle strobe, sample_in valid; always accepted
sample_out  output  SAMPLE_WIDTH  signed decimated sample
sample_valid_out  output  1  sample_out holds an unconsumed result
sample_ready_in  input  1  downstream accepts sample_out when high with sample_valid_out
overrun_out  output  1  sticky: a result was dropped because the output was full
clr_overrun_in  input  1  synchronous clear of overrun_out
phase_out  output  DECIM_LOG2  number of samples accumulated in the current block (0..N-1)

Behaviour:
- Reset (rst_in low, asynchronous): the following are all 0: accumulator, phase counter, sample_out, sample_valid_out, overrun_out, phase_out. Reset mid-block discards the partial sum.
- Accumulator: signed, SAMPLE_WIDTH+DECIM_LOG2 bits. Each sample is sign-extended before it is added. Sum of N full-scale samples cannot overflow.
- Each cycle with sample_valid_in=1:
  - phase < N-1: acc <= acc + sample_in; phase++.
  - phase == N-1: result = (acc + sample_in) >>> DECIM_LOG2 (arithmetic shift, floor). acc <= 0; phase <= 0; result is offered to the output register.
- Latency: sample_out/sample_valid_out update on the clock edge that accepts the Nth sample. Visible one cycle after the Nth strobe is sampled.
- Output register (1-deep):
  - Transfer occurs when sample_valid_out && sample_ready_in.
  - Empty, or draining this cycle: result loaded, sample_valid_out=1.
  - Full and not draining: result dropped; sample_out unchanged; overrun_out <= 1.
  - Drain with no new result: sample_valid_out <= 0; sample_out keeps its last value.
  - Simultaneous drain and new result: new result loaded, sample_valid_out stays 1, no overrun.
- sample_out must stay stable while sample_valid_out=1 and sample_ready_in=0.
- overrun_out: set by a drop, cleared by clr_overrun_in. A set and a clear in the same cycle leave it set.
- Phase wraps N-1 -> 0 only on an accepted sample. Idle cycles (sample_valid_in=0) hold all state.
- Saturation is never needed: the average of in-range samples is always in range.

Optional Feature:
MIC_DECIM_ROUND_EN
- Defined: result = (acc + sample_in + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, i.e. round half toward +inf. The bias cannot overflow the accumulator, and results stay within [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
- Undefined: plain floor (truncating arithmetic shift) as above.
- All other behaviour identical.

Test Plan:
1. Reset: hold rst_in low mid-run, asynchronously -> sample_out=0, sample_valid_out=0, overrun_out=0, phase_out=0 without a clock edge.
2. DC: 8 strobes of 24'h000100 with ready=1 -> sample_valid_out=1 for one cycle after the 8th strobe, sample_out=24'h000100; phase_out steps 0..7 and back to 0.
3. Extremes and rounding:
   - 8 x 24'h7FFFFF -> 24'h7FFFFF.
   - 8 x 24'h800000 -> 24'h800000.
   - Samples 1,-2,1,-2,1,-2,1,-2 (sum -4) -> 24'hFFFFFF (floor); with MIC_DECIM_ROUND_EN -> 24'h000000.
4. Backpressure:
   - ready=0, 16 strobes of 24'h000010 then 24'h000020 -> sample_out holds 24'h000010, overrun_out=1.
   - Raise ready -> one transfer, then sample_valid_out=0.
   - Pulse clr_overrun_in -> overrun_out=0.
5. Simultaneous: output full, ready=1 in the same cycle the next block's 8th strobe arrives -> old value transferred, new value loaded, sample_valid_out stays 1, overrun_out stays 0.
6. Reset mid-block: 5 strobes of 24'h7FFFFF, assert/release rst_in, then 8 strobes of 24'h000010 -> sample_out=24'h000010, no residue from the partial block.

Source files
------------

// File: rtl/mic_decimator.sv
// Boxcar decimator: averages blocks of 2^DECIM_LOG2 signed samples into a 1-deep valid/ready output.
// Define MIC_DECIM_ROUND_EN to round half toward +inf instead of flooring.
module mic_decimator #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int DECIM_LOG2   = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid_out,
  input  logic                    sample_ready_in,
  output logic                    overrun_out,
  input  logic                    clr_overrun_in,
  output logic [DECIM_LOG2-1:0]   phase_out
);

  localparam int ACC_W = SAMPLE_WIDTH + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;
  localparam logic [DECIM_LOG2-1:0] PHASE_ONE  = DECIM_LOG2'(1);

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [DECIM_LOG2-1:0]   phase_q, phase_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic [ACC_W-1:0]        sample_ext;
  logic [ACC_W-1:0]        acc_sum;
  logic [SAMPLE_WIDTH-1:0] result;
  logic [DECIM_LOG2-1:0]   round_unused;
  logic                    block_done;
  logic                    drain;

  assign sample_ext = {{DECIM_LOG2{sample_in[SAMPLE_WIDTH-1]}}, sample_in};
  assign acc_sum    = acc_q + sample_ext;
  assign block_done = sample_valid_in && (phase_q == PHASE_LAST);
  assign drain      = valid_q && sample_ready_in;

  // Taking the top SAMPLE_WIDTH bits is the arithmetic shift right by DECIM_LOG2.
`ifdef MIC_DECIM_ROUND_EN
  localparam logic [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (DECIM_LOG2 - 1);
  assign {result, round_unused} = acc_sum + ROUND_BIAS;
`else
  assign {result, round_unused} = acc_sum;
`endif

  always_comb begin
    acc_d     = acc_q;
    phase_d   = phase_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (sample_valid_in) begin
      if (block_done) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = acc_sum;
        phase_d = phase_q + PHASE_ONE;
      end
    end
    if (clr_overrun_in) begin
      overrun_d = 1'b0;
    end
    // A drop in the same cycle as a clear wins, so the event is not lost.
    if (block_done) begin
      if (!valid_q || drain) begin
        sample_d = result;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_q     <= '0;
      phase_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign overrun_out      = overrun_q;
  assign phase_out        = phase_q;

endmodule

// File: tb/tb_mic_decimator.sv
// tb/tb_mic_decimator.sv - directed self-checking bench for mic_decimator.
module tb_mic_decimator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [23:0] sample_in;
  logic        sample_valid_in;
  logic [23:0] sample_out;
  logic        sample_valid_out;
  logic        sample_ready_in;
  logic        overrun_out;
  logic        clr_overrun_in;
  logic [2:0]  phase_out;

  int checks   = 0;
  int failures = 0;

  mic_decimator #(.SAMPLE_WIDTH(24), .DECIM_LOG2(3)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .sample_ready_in  (sample_ready_in),
    .overrun_out      (overrun_out),
    .clr_overrun_in   (clr_overrun_in),
    .phase_out        (phase_out)
  );

  always #5 clk_in = ~clk_in;

  // Drives n back-to-back strobes, returning at the negedge after the last accepting edge.
  task automatic send_const(input logic [23:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      sample_in       = s;
      sample_valid_in = 1'b1;
    end
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  task automatic test_reset;
    sample_ready_in = 1'b0;
    send_const(24'h000100, 16);
    send_const(24'h000100, 3);
    checks++;
    if (overrun_out !== 1'b1 || sample_valid_out !== 1'b1 || phase_out !== 3'd3) begin
      failures++;
      $display("FAIL reset_precond ovr=%b vld=%b phase=%0d exp 1 1 3", overrun_out, sample_valid_out, phase_out);
    end
    #1 rst_in = 1'b0;
    #1;
    checks++;
    if (sample_out !== 24'h0 || sample_valid_out !== 1'b0 || overrun_out !== 1'b0 || phase_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_async out=%h vld=%b ovr=%b phase=%0d exp 000000 0 0 0",
               sample_out, sample_valid_out, overrun_out, phase_out);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_dc;
    sample_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      checks++;
      if (phase_out !== 3'(i)) begin
        failures++;
        $display("FAIL dc_phase got=%0d exp=%0d", phase_out, i);
      end
      sample_in       = 24'h000100;
      sample_valid_in = 1'b1;
    end
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== 24'h000100 || phase_out !== 3'd0) begin
      failures++;
      $display("FAIL dc_result vld=%b out=%h phase=%0d exp 1 000100 0", sample_valid_out, sample_out, phase_out);
    end
    @(negedge clk_in);
    checks++;
    if (sample_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL dc_one_cycle vld=%b exp=0", sample_valid_out);
    end
  endtask

  task automatic test_extremes;
    logic [23:0] exp_alt;
`ifdef MIC_DECIM_ROUND_EN
    exp_alt = 24'h000000;
`else
    exp_alt = 24'hFFFFFF;
`endif
    sample_ready_in = 1'b1;
    send_const(24'h7FFFFF, 8);
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== 24'h7FFFFF) begin
      failures++;
      $display("FAIL ext_max vld=%b out=%h exp 1 7fffff", sample_valid_out, sample_out);
    end
    send_const(24'h800000, 8);
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== 24'h800000) begin
      failures++;
      $display("FAIL ext_min vld=%b out=%h exp 1 800000", sample_valid_out, sample_out);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      sample_in       = (i % 2 == 0) ? 24'h000001 : 24'hFFFFFE;
      sample_valid_in = 1'b1;
    end
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== exp_alt) begin
      failures++;
      $display("FAIL ext_round vld=%b out=%h exp 1 %h", sample_valid_out, sample_out, exp_alt);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk_in);
    sample_ready_in = 1'b0;
    send_const(24'h000010, 8);
    send_const(24'h000020, 8);
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== 24'h000010 || overrun_out !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold vld=%b out=%h ovr=%b exp 1 000010 1", sample_valid_out, sample_out, overrun_out);
    end
    sample_ready_in = 1'b1;
    @(negedge clk_in);
    sample_ready_in = 1'b0;
    checks++;
    if (sample_valid_out !== 1'b0 || sample_out !== 24'h000010 || overrun_out !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain vld=%b out=%h ovr=%b exp 0 000010 1", sample_valid_out, sample_out, overrun_out);
    end
    clr_overrun_in = 1'b1;
    @(negedge clk_in);
    clr_overrun_in = 1'b0;
    checks++;
    if (overrun_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_clear ovr=%b exp=0", overrun_out);
    end
  endtask

  task automatic test_back_to_back;
    sample_ready_in = 1'b0;
    send_const(24'h000030, 8);
    send_const(24'h000040, 7);
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== 24'h000030 || phase_out !== 3'd7) begin
      failures++;
      $display("FAIL b2b_pre vld=%b out=%h phase=%0d exp 1 000030 7", sample_valid_out, sample_out, phase_out);
    end
    sample_in       = 24'h000040;
    sample_valid_in = 1'b1;
    sample_ready_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    sample_ready_in = 1'b0;
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== 24'h000040 || overrun_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_load vld=%b out=%h ovr=%b exp 1 000040 0", sample_valid_out, sample_out, overrun_out);
    end
    sample_ready_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (sample_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain vld=%b exp=0", sample_valid_out);
    end
  endtask

  task automatic test_reset_mid_block;
    sample_ready_in = 1'b1;
    send_const(24'h7FFFFF, 5);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    checks++;
    if (phase_out !== 3'd0) begin
      failures++;
      $display("FAIL rst_mid_phase got=%0d exp=0", phase_out);
    end
    send_const(24'h000010, 8);
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== 24'h000010) begin
      failures++;
      $display("FAIL rst_mid_result vld=%b out=%h exp 1 000010", sample_valid_out, sample_out);
    end
  endtask

  initial begin
    rst_in          = 1'b0;
    sample_in       = 24'h0;
    sample_valid_in = 1'b0;
    sample_ready_in = 1'b0;
    clr_overrun_in  = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    test_reset;
    test_dc;
    test_extremes;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_block;
    repeat (2) @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
